// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong sync/renderer blocks and the game controller.
interface pong_game_ctrl_if;
  logic        frame_tick;
  logic [1:0]  btn;
  logic        hit;
  logic        miss;
  logic        video_on;
  logic [3:0]  text_on;
  logic [11:0] text_rgb;
  logic        graph_on;
  logic [11:0] graph_rgb;
  logic        gra_still;
  logic [1:0]  state;
  logic [1:0]  ball_cnt;
  logic [7:0]  score;
  logic [11:0] rgb;

  modport master (
    output frame_tick, btn, hit, miss, video_on, text_on, text_rgb, graph_on, graph_rgb,
    input  gra_still, state, ball_cnt, score, rgb
  );

  modport slave (
    input  frame_tick, btn, hit, miss, video_on, text_on, text_rgb, graph_on, graph_rgb,
    output gra_still, state, ball_cnt, score, rgb
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: round/ball/score bookkeeping, inter-round timer
// and the registered final pixel mux between text, graphics and background.
module pong_game_ctrl #(
  parameter int unsigned BALLS        = 3,
  parameter int unsigned TIMER_FRAMES = 120,
  parameter logic [11:0] BG_RGB       = 12'h0AF
) (
  input logic              clk,
  input logic              reset_n,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned TIMER_NEED = $clog2(TIMER_FRAMES + 1);
  localparam int unsigned TIMER_W    = (TIMER_NEED < 7) ? 7 : TIMER_NEED;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t               st;
  logic [1:0]           ball_cnt;
  logic [7:0]           score;
  logic [TIMER_W-1:0]   timer;
  logic                 gra_still;
  logic [11:0]          rgb;
  logic [11:0]          pix_c;
  logic                 btn_any_c;

  assign btn_any_c = |bus.btn;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Pixel priority; the logo region sits behind the graphics layer.
  always_comb begin
    pix_c = BG_RGB;
    if (!bus.video_on) begin
      pix_c = 12'h000;
    end else if (bus.text_on[0] ||
                 (bus.text_on[2] && st == NEWGAME) ||
                 (bus.text_on[3] && st == OVER)) begin
      pix_c = bus.text_rgb;
    end else if (bus.graph_on) begin
      pix_c = bus.graph_rgb;
    end else if (bus.text_on[1]) begin
      pix_c = bus.text_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= NEWGAME;
      ball_cnt  <= 2'(BALLS);
      score     <= 8'h00;
      timer     <= '0;
      gra_still <= 1'b1;
      rgb       <= 12'h000;
    end else begin
      rgb <= pix_c;
      case (st)
        NEWGAME: begin
          if (btn_any_c) begin
            st        <= PLAY;
            gra_still <= 1'b0;
          end
        end
        PLAY: begin
          // A miss outranks a simultaneous hit.
          if (bus.miss) begin
            timer     <= TIMER_W'(TIMER_FRAMES);
            gra_still <= 1'b1;
            if (ball_cnt <= 2'd1) begin
              ball_cnt <= 2'd0;
              st       <= OVER;
            end else begin
              ball_cnt <= ball_cnt - 2'd1;
              st       <= NEWBALL;
            end
          end else if (bus.hit) begin
            score <= bcd_inc(score);
          end
        end
        NEWBALL: begin
          if (timer != '0) begin
            if (bus.frame_tick) timer <= timer - TIMER_W'(1);
          end else if (btn_any_c) begin
            st        <= PLAY;
            gra_still <= 1'b0;
          end
        end
        OVER: begin
          if (timer != '0) begin
            if (bus.frame_tick) timer <= timer - TIMER_W'(1);
          end else begin
            st       <= NEWGAME;
            ball_cnt <= 2'(BALLS);
            score    <= 8'h00;
          end
        end
        default: st <= NEWGAME;
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.ball_cnt  = ball_cnt;
  assign bus.score     = score;
  assign bus.gra_still = gra_still;
  assign bus.rgb       = rgb;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: game flow, BCD score, countdowns, pixel mux, async reset.
module tb_pong_game_ctrl;

  localparam logic [11:0] TXT = 12'hF00;
  localparam logic [11:0] GFX = 12'h0F0;
  localparam logic [11:0] BG  = 12'h0AF;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(.BALLS(3), .TIMER_FRAMES(120), .BG_RGB(BG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn        = 2'b00;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    bus.video_on   = 1'b0;
    bus.text_on    = 4'b0000;
    bus.text_rgb   = TXT;
    bus.graph_on   = 1'b0;
    bus.graph_rgb  = GFX;

    #12;
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_balls", 32'(bus.ball_cnt), 32'h3);
    check("rst_score", 32'(bus.score), 32'h00);
    check("rst_still", 32'(bus.gra_still), 32'h1);
    check("rst_rgb", 32'(bus.rgb), 32'h000);
    tick();
    reset_n = 1'b1;
    tick();

    // Start a game.
    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    check("start_state", 32'(bus.state), 32'h1);
    check("start_still", 32'(bus.gra_still), 32'h0);
    check("start_balls", 32'(bus.ball_cnt), 32'h3);
    check("start_score", 32'(bus.score), 32'h00);

    for (int i = 0; i < 11; i++) pulse_hit();
    check("score_11", 32'(bus.score), 32'h11);
    for (int i = 0; i < 88; i++) pulse_hit();
    check("score_99", 32'(bus.score), 32'h99);
    pulse_hit();
    check("score_wrap", 32'(bus.score), 32'h00);

    // First miss -> NEWBALL countdown with button held.
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("miss1_state", 32'(bus.state), 32'h2);
    check("miss1_balls", 32'(bus.ball_cnt), 32'h2);
    check("miss1_still", 32'(bus.gra_still), 32'h1);
    bus.btn = 2'b01;
    frames(119);
    check("nb_119", 32'(bus.state), 32'h2);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    check("nb_120", 32'(bus.state), 32'h2);
    tick();
    check("nb_play", 32'(bus.state), 32'h1);
    check("nb_still", 32'(bus.gra_still), 32'h0);
    bus.btn = 2'b00;

    // Hit/miss while not in PLAY are ignored; get to ball_cnt==1.
    pulse_hit();
    pulse_hit();
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    pulse_hit();
    check("nb2_balls", 32'(bus.ball_cnt), 32'h1);
    check("nb2_score", 32'(bus.score), 32'h02);
    frames(120);
    bus.btn = 2'b10;
    tick();
    bus.btn = 2'b00;
    check("nb2_play", 32'(bus.state), 32'h1);

    // Simultaneous hit and miss on last ball: miss wins.
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    tick();
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    check("over_state", 32'(bus.state), 32'h3);
    check("over_balls", 32'(bus.ball_cnt), 32'h0);
    check("over_score", 32'(bus.score), 32'h02);
    check("over_still", 32'(bus.gra_still), 32'h1);

    // Pixel mux while OVER.
    bus.video_on = 1'b1;
    bus.text_on  = 4'b1000;
    tick();
    check("mux_over_txt", 32'(bus.rgb), 32'(TXT));
    bus.text_on  = 4'b0000;

    bus.btn = 2'b11;
    frames(119);
    check("over_119", 32'(bus.state), 32'h3);
    bus.btn = 2'b00;
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    check("over_120", 32'(bus.state), 32'h3);
    tick();
    check("ng_state", 32'(bus.state), 32'h0);
    check("ng_balls", 32'(bus.ball_cnt), 32'h3);
    check("ng_score", 32'(bus.score), 32'h00);
    check("ng_still", 32'(bus.gra_still), 32'h1);

    // Pixel mux in NEWGAME.
    bus.text_on  = 4'b0010;
    bus.graph_on = 1'b1;
    tick();
    check("mux_logo_gfx", 32'(bus.rgb), 32'(GFX));
    bus.graph_on = 1'b0;
    tick();
    check("mux_logo", 32'(bus.rgb), 32'(TXT));
    bus.text_on  = 4'b0100;
    tick();
    check("mux_rules_ng", 32'(bus.rgb), 32'(TXT));
    bus.text_on  = 4'b0000;
    tick();
    check("mux_bg", 32'(bus.rgb), 32'(BG));

    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    bus.text_on = 4'b1000;
    tick();
    check("mux_over_play", 32'(bus.rgb), 32'(BG));
    bus.text_on = 4'b0100;
    tick();
    check("mux_rules_play", 32'(bus.rgb), 32'(BG));
    bus.text_on  = 4'b0001;
    bus.graph_on = 1'b1;
    tick();
    check("mux_score", 32'(bus.rgb), 32'(TXT));
    bus.video_on = 1'b0;
    tick();
    check("mux_blank", 32'(bus.rgb), 32'h000);
    bus.video_on = 1'b1;
    bus.text_on  = 4'b0000;
    tick();
    check("mux_pre_rst", 32'(bus.rgb), 32'(GFX));

    // Async reset mid-NEWBALL countdown.
    pulse_hit();
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    frames(5);
    check("pre_rst_state", 32'(bus.state), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'h0);
    check("arst_balls", 32'(bus.ball_cnt), 32'h3);
    check("arst_score", 32'(bus.score), 32'h00);
    check("arst_still", 32'(bus.gra_still), 32'h1);
    check("arst_rgb", 32'(bus.rgb), 32'h000);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rgb", 32'(bus.rgb), 32'(GFX));
    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    check("post_rst_play", 32'(bus.state), 32'h1);
    check("post_rst_balls", 32'(bus.ball_cnt), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
